// File: rtl/dff_share_arb_pkg.sv
// Shared types and constants for the dff_share_arb round-robin DFF sharing block.
package dff_share_arb_pkg;

    typedef logic [0:0] arb_state_e;
    localparam arb_state_e ARB   = 1'b0;
    localparam arb_state_e BURST = 1'b1;

    localparam int unsigned QUEUE_DEPTH = 2;
    localparam int unsigned QUEUE_PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned QUEUE_CNT_W = $clog2(QUEUE_DEPTH + 1);

    // Entry fields are sized for the largest supported configuration (8 requesters, 32-bit words)
    localparam int unsigned RSP_ID_MAX_W   = 3;
    localparam int unsigned RSP_DATA_MAX_W = 32;

    typedef struct packed {
        logic [RSP_ID_MAX_W-1:0]   id;
        logic [RSP_DATA_MAX_W-1:0] data;
    } rsp_entry_t;

endpackage

// File: rtl/dff_share_arb_if.sv
// Request, DFF and response signals of dff_share_arb; slave is the arbiter's view.
interface dff_share_arb_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         dff_inp;
    logic [DATA_W-1:0]         dff_outp;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_data;

    modport master (
        output req_valid, req_data, dff_outp, rsp_ready,
        input  req_ready, dff_inp, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_data, dff_outp, rsp_ready,
        output req_ready, dff_inp, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/dff_share_rsp_q.sv
// Small response FIFO holding tagged DFF results; simultaneous push and pop are both honoured.
module dff_share_rsp_q
    import dff_share_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  rsp_entry_t             push_entry_i,
    input  logic                   pop_i,
    output rsp_entry_t             head_o,
    output logic                   valid_o,
    output logic [QUEUE_CNT_W-1:0] count_o
);
    rsp_entry_t             mem_q [QUEUE_DEPTH];
    logic [QUEUE_PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [QUEUE_CNT_W-1:0] count_q;
    logic                   do_push, do_pop;

    function automatic logic [QUEUE_PTR_W-1:0] ptr_inc(input logic [QUEUE_PTR_W-1:0] p);
        return (p == QUEUE_PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != QUEUE_CNT_W'(QUEUE_DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/dff_share_arb.sv
// Round-robin sequencer sharing one external DFF stage among NUM_REQ requesters, with bursts.
// Optional DFF_SHARE_ARB_HOLD_INP_EN: dff_inp holds the last issued word on idle cycles.
module dff_share_arb
    import dff_share_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input logic            clk,
    input logic            rst_n,
    dff_share_arb_if.slave bus
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned OCC_W = QUEUE_CNT_W + 1;

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        owner_q, owner_d, owner_inc;
    logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic                   in_flight_q;
    logic [ID_W-1:0]        flight_id_q;

    logic [QUEUE_CNT_W-1:0] q_count;
    logic                   q_valid;
    rsp_entry_t             q_head, q_push_entry;
    logic                   pop, issue_ok;
    logic [OCC_W-1:0]       occupancy;

    logic                   continue_burst;
    logic [ID_W-1:0]        search_start, search_idx;
    logic                   search_hit;
    logic [ID_W:0]          cand;

    logic                   grant_vld;
    logic [ID_W-1:0]        grant_idx;
    logic [DATA_W-1:0]      grant_data, idle_inp;
    logic                   unused_head_bits;

    assign pop       = q_valid && bus.rsp_ready;
    assign occupancy = OCC_W'(q_count) + OCC_W'(in_flight_q) - OCC_W'(pop);
    assign issue_ok  = (occupancy < OCC_W'(QUEUE_DEPTH));

    assign owner_inc      = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign continue_burst = (state_q == BURST) && bus.req_valid[owner_q]
                            && (burst_cnt_q < CNT_W'(MAX_BURST));
    // Leaving a burst re-arbitrates in the same cycle, starting just after the old owner
    assign search_start   = (state_q == BURST) ? owner_inc : rr_ptr_q;

    always_comb begin
        search_hit = 1'b0;
        search_idx = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, search_start} + (ID_W + 1)'(k);
            if (cand >= (ID_W + 1)'(NUM_REQ)) begin
                cand = cand - (ID_W + 1)'(NUM_REQ);
            end
            if (!search_hit && bus.req_valid[cand[ID_W-1:0]]) begin
                search_hit = 1'b1;
                search_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        grant_vld   = 1'b0;
        grant_idx   = owner_q;
        // rst_n gating keeps req_ready low for the whole reset, even mid-cycle
        if (issue_ok && rst_n) begin
            if (continue_burst) begin
                grant_vld   = 1'b1;
                burst_cnt_d = burst_cnt_q + 1'b1;
            end else begin
                if (state_q == BURST) begin
                    rr_ptr_d = owner_inc;
                end
                if (search_hit) begin
                    grant_vld   = 1'b1;
                    grant_idx   = search_idx;
                    owner_d     = search_idx;
                    burst_cnt_d = CNT_W'(1);
                    state_d     = BURST;
                end else begin
                    state_d = ARB;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            in_flight_q <= 1'b0;
            flight_id_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            in_flight_q <= grant_vld;
            if (grant_vld) begin
                flight_id_q <= grant_idx;
            end
        end
    end

`ifdef DFF_SHARE_ARB_HOLD_INP_EN
    logic [DATA_W-1:0] hold_inp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_inp_q <= '0;
        end else if (grant_vld) begin
            hold_inp_q <= grant_data;
        end
    end

    assign idle_inp = hold_inp_q;
`else
    assign idle_inp = '0;
`endif

    always_comb begin
        q_push_entry      = '0;
        q_push_entry.id   = RSP_ID_MAX_W'(flight_id_q);
        q_push_entry.data = RSP_DATA_MAX_W'(bus.dff_outp);
    end

    dff_share_rsp_q u_rsp_q (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (in_flight_q),
        .push_entry_i (q_push_entry),
        .pop_i        (pop),
        .head_o       (q_head),
        .valid_o      (q_valid),
        .count_o      (q_count)
    );

    assign bus.req_ready = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
    assign bus.dff_inp   = grant_vld ? grant_data : idle_inp;
    assign bus.rsp_valid = q_valid;
    assign bus.rsp_id    = q_head.id[ID_W-1:0];
    assign bus.rsp_data  = q_head.data[DATA_W-1:0];

    assign unused_head_bits = ^{q_head.id, q_head.data};

endmodule

// File: tb/tb_dff_share_arb.sv
// Bench for dff_share_arb: two instances (MAX_BURST 4 and 1) share stimulus, each against its own model.
module tb_dff_share_arb;
    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic           rsp_ready = 1'b0;

    dff_share_arb_if #(.NUM_REQ(N), .DATA_W(W)) bus0 ();
    dff_share_arb_if #(.NUM_REQ(N), .DATA_W(W)) bus1 ();

    assign bus0.req_valid = req_valid;
    assign bus0.req_data  = req_data;
    assign bus0.rsp_ready = rsp_ready;
    assign bus1.req_valid = req_valid;
    assign bus1.req_data  = req_data;
    assign bus1.rsp_ready = rsp_ready;

    initial begin
        bus0.dff_outp = '0;
        bus1.dff_outp = '0;
    end
    always @(posedge clk) begin
        bus0.dff_outp <= bus0.dff_inp;
        bus1.dff_outp <= bus1.dff_inp;
    end

    dff_share_arb #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(4)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    dff_share_arb #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    logic [N-1:0] o_ready [2];
    logic [W-1:0] o_inp   [2];
    logic         o_rvld  [2];
    logic [1:0]   o_rid   [2];
    logic [W-1:0] o_rdata [2];
    assign o_ready[0] = bus0.req_ready;
    assign o_ready[1] = bus1.req_ready;
    assign o_inp[0]   = bus0.dff_inp;
    assign o_inp[1]   = bus1.dff_inp;
    assign o_rvld[0]  = bus0.rsp_valid;
    assign o_rvld[1]  = bus1.rsp_valid;
    assign o_rid[0]   = bus0.rsp_id;
    assign o_rid[1]   = bus1.rsp_id;
    assign o_rdata[0] = bus0.rsp_data;
    assign o_rdata[1] = bus1.rsp_data;

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           cyc;
    } ent_t;

    // Reference model: current run owner (-1 = none), run length, rotation start, outstanding words
    int           maxb [2] = '{4, 1};
    int           owner [2];
    int           run [2];
    int           ptr [2];
    logic [W-1:0] last_inp [2];
    ent_t         pend [2][$];
    int           glog [2][$];
    int           cyc = 0;
    bit           in_rst = 1'b1;
    int           total = 0;
    int           bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            owner[d]    = -1;
            run[d]      = 0;
            ptr[d]      = 0;
            last_inp[d] = '0;
            pend[d].delete();
            glog[d].delete();
        end
    endtask

    task automatic model_cycle(input int d);
        int           g;
        bit           vis;
        bit           pop;
        logic [N-1:0] exp_ready;
        logic [W-1:0] exp_inp;
        g   = -1;
        vis = !in_rst && (pend[d].size() > 0) && (pend[d][0].cyc + 2 <= cyc);
        check($sformatf("rsp_valid[d%0d c%0d]", d, cyc), 32'(o_rvld[d]), 32'(vis));
        if (vis) begin
            check($sformatf("rsp_id[d%0d c%0d]", d, cyc), 32'(o_rid[d]), 32'(pend[d][0].id));
            check($sformatf("rsp_data[d%0d c%0d]", d, cyc), 32'(o_rdata[d]), 32'(pend[d][0].data));
        end else if (in_rst) begin
            check($sformatf("rst_rsp_id[d%0d]", d), 32'(o_rid[d]), 32'd0);
            check($sformatf("rst_rsp_data[d%0d]", d), 32'(o_rdata[d]), 32'd0);
        end
        pop = vis && rsp_ready;
        if (!in_rst && (pend[d].size() - int'(pop) < 2)) begin
            if (owner[d] >= 0 && req_valid[owner[d]] && run[d] < maxb[d]) begin
                g = owner[d];
                run[d]++;
            end else begin
                if (owner[d] >= 0) begin
                    ptr[d]   = (owner[d] + 1) % int'(N);
                    owner[d] = -1;
                end
                for (int k = 0; k < int'(N); k++) begin
                    if (g < 0 && req_valid[(ptr[d] + k) % int'(N)]) g = (ptr[d] + k) % int'(N);
                end
                if (g >= 0) begin
                    owner[d] = g;
                    run[d]   = 1;
                end
            end
        end
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
`ifdef DFF_SHARE_ARB_HOLD_INP_EN
        exp_inp = (g >= 0) ? req_data[g*W +: W] : last_inp[d];
`else
        exp_inp = (g >= 0) ? req_data[g*W +: W] : '0;
`endif
        check($sformatf("req_ready[d%0d c%0d]", d, cyc), 32'(o_ready[d]), 32'(exp_ready));
        check($sformatf("dff_inp[d%0d c%0d]", d, cyc), 32'(o_inp[d]), 32'(exp_inp));
        for (int i = 0; i < int'(N); i++) begin
            if (o_ready[d][i]) glog[d].push_back(i);
        end
        if (pop) void'(pend[d].pop_front());
        if (g >= 0) begin
            pend[d].push_back('{id: g, data: req_data[g*W +: W], cyc: cyc});
            last_inp[d] = req_data[g*W +: W];
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle(0);
        model_cycle(1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        in_rst = 1'b1;
        model_clear();
        step();
        step();
        rst_n  = 1'b1;
        in_rst = 1'b0;
    endtask

    task automatic check_glog(input int d, input string tag, input int exp_q[$]);
        check($sformatf("%s_len[d%0d]", tag, d), 32'(glog[d].size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[d%0d][%0d]", tag, d, i),
                  (i < glog[d].size()) ? 32'(glog[d][i]) : 32'hffff_ffff, 32'(exp_q[i]));
        end
    endtask

    initial begin
        int words;
        #1;
        do_reset();
        check("reset_req_ready", 32'(bus0.req_ready), 32'd0);
        check("reset_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        check("reset_dff_inp", 32'(bus0.dff_inp), 32'd0);

        // Single requester, latency 2
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        req_data  = {8'h00, 8'h00, 8'h00, 8'hA5};
        step();
        req_valid = '0;
        check("single_lat1_valid", 32'(bus0.rsp_valid), 32'd0);
        step();
        check("single_lat2_valid", 32'(bus0.rsp_valid), 32'd1);
        check("single_lat2_id", 32'(bus0.rsp_id), 32'd0);
        check("single_lat2_data", 32'(bus0.rsp_data), 32'hA5);
        step();
        step();
        check_glog(0, "single_grants", '{0});

        // All requesters streaming
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            req_data = {$urandom, $urandom};
            step();
        end
        req_valid = '0;
        step();
        step();
        step();
        check_glog(0, "all_b4", '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2});
        check_glog(1, "all_b1", '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3});

        // Requesters 1 and 3: pointer wraps 3 -> 0 -> 1
        do_reset();
        req_valid = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            req_data = {$urandom, $urandom};
            step();
        end
        req_valid = '0;
        step();
        step();
        step();
        check_glog(0, "odd_b4", '{1, 1, 1, 1, 3, 3, 3, 3});
        check_glog(1, "odd_b1", '{1, 3, 1, 3, 1, 3, 1, 3});

        // Backpressure with requester 2 streaming 10, 11, ...
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            words    = glog[0].size();
            req_data = {8'h00, 8'(8'h10 + words), 8'h00, 8'h00};
            step();
        end
        check("bp_accepts", 32'(glog[0].size()), 32'd2);
        check("bp_hold_data", 32'(bus0.rsp_data), 32'h10);
        check("bp_ready_low", 32'(bus0.req_ready), 32'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            words    = glog[0].size();
            req_data = {8'h00, 8'(8'h10 + words), 8'h00, 8'h00};
            step();
        end
        req_valid = '0;
        step();
        step();
        step();
        check("bp_resume_accepts", 32'(glog[0].size()), 32'd10);

        // Reset mid-burst with a full queue
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_data = {$urandom, $urandom};
            step();
        end
        check("pre_rst_valid", 32'(bus0.rsp_valid), 32'd1);
        rst_n     = 1'b0;
        in_rst    = 1'b1;
        model_clear();
        req_valid = 4'b0110;
        #2;
        check("rst_drop_valid0", 32'(bus0.rsp_valid), 32'd0);
        check("rst_drop_ready0", 32'(bus0.req_ready), 32'd0);
        check("rst_drop_valid1", 32'(bus1.rsp_valid), 32'd0);
        check("rst_drop_ready1", 32'(bus1.req_ready), 32'd0);
        step();
        rst_n     = 1'b1;
        in_rst    = 1'b0;
        rsp_ready = 1'b1;
        step();
        check("post_rst_first0", (glog[0].size() > 0) ? 32'(glog[0][0]) : 32'hffff_ffff, 32'd1);
        check("post_rst_first1", (glog[1].size() > 0) ? 32'(glog[1][0]) : 32'hffff_ffff, 32'd1);
        req_valid = '0;
        step();
        step();
        step();

        // Idle after an issue of 3C
        do_reset();
        req_valid = 4'b0001;
        req_data  = {8'h00, 8'h00, 8'h00, 8'h3C};
        step();
        req_valid = '0;
        req_data  = '0;
        step();
        step();
        step();
`ifdef DFF_SHARE_ARB_HOLD_INP_EN
        check("idle_inp_hold", 32'(bus0.dff_inp), 32'h3C);
`else
        check("idle_inp_zero", 32'(bus0.dff_inp), 32'h00);
`endif

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req_valid = N'($urandom_range(0, 15));
            req_data  = {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("drain_valid0", 32'(bus0.rsp_valid), 32'd0);
        check("drain_valid1", 32'(bus1.rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dff_share_arb.md
Name: dff_share_arb

Overview:
- Round-robin arbiter/sequencer that shares one registered datapath stage (the `dut` DFF: `inp` sampled, `outp` valid one clock later) between NUM_REQ requesters.
- Issues at most one requester word per cycle into the DFF and tags the returning word with the requester id.
- Buffers results in a 2-entry response queue with valid/ready backpressure.
- Sits between requester agents and the DFF instance in the top-level design.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of each request word and of DFF `inp`/`outp`.
- MAX_BURST, 4, maximum consecutive grants to one requester before forced rotation (1..15).
- ID_W, $clog2(NUM_REQ), derived; requester id width.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NUM_REQ, per-requester request.
- req_data, input, NUM_REQ*DATA_W, packed request words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready, output, NUM_REQ, one-hot accept; a transfer occurs when req_valid[i] && req_ready[i].
- dff_inp, output, DATA_W, drives DFF `inp`.
- dff_outp, input, DATA_W, from DFF `outp`.
- rsp_valid, output, 1, response available.
- rsp_ready, input, 1, consumer accepts the response.
- rsp_id, output, ID_W, requester index of the response.
- rsp_data, output, DATA_W, DFF output word.

Behaviour:
- Reset (async, rst_n=0):
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, dff_inp=0.
  - rr pointer=0, burst count=0, FSM=ARB, queue empty, in_flight=0.
  - In-flight and queued words are discarded. Release is synchronous to clk.
- Pipeline:
  - Accept in cycle N; dff_inp equals the granted req_data combinationally in cycle N.
  - At edge N+1: in_flight=1 and issued id registered.
  - At edge N+2: dff_outp and the id are pushed into the queue.
  - rsp_valid is high in N+2 at earliest (latency 2).
- Issue allowed iff (queue_count + in_flight − pop) < 2, where pop = rsp_valid && rsp_ready. The queue therefore never overflows.
- If issue is not allowed, or no req_valid is set: req_ready=0 and dff_inp=0.
- FSM ARB:
  - Grant the first requester with req_valid set, searching from rr pointer upward with wrap (NUM_REQ−1 → 0).
  - On a grant, set burst count=1 and go to BURST.
- FSM BURST:
  - Stay on the same requester while its req_valid=1, issue is allowed, and burst count < MAX_BURST; increment the count on each grant.
  - Exit to ARB when the requester drops req_valid or the count reaches MAX_BURST. On exit, rr pointer = winner+1 (mod NUM_REQ).
  - A stall (issue not allowed) holds the state and count, and grants nothing.
- MAX_BURST=1 degenerates to pure per-cycle round robin.
- req_ready is one-hot or zero; it is never asserted for a requester whose req_valid=0.
- Queue:
  - Push and pop in the same cycle are both honoured.
  - Outputs come from the head entry; rsp_id/rsp_data hold stable while rsp_valid && !rsp_ready.
- Responses return in issue order.

Optional Feature:
- Macro DFF_SHARE_ARB_HOLD_INP_EN.
- Defined: on non-issue cycles dff_inp holds the last issued word instead of 0, reducing toggle on the DFF input. Reset value is still 0.
- Undefined: dff_inp=0 on non-issue cycles. Functional responses are identical in both builds.

Decomposition:
- Package dff_share_arb_pkg holds:
  - arb_state_e enum {ARB, BURST};
  - a rsp_entry_t struct {id, data};
  - the QUEUE_DEPTH=2 constant.
- Sub-module dff_share_rsp_q (2-entry FIFO of rsp_entry_t with count, push, pop). The arbiter FSM and pointer stay in the top.

Test Plan:
- Single requester: req_valid=4'b0001, data 8'hA5, rsp_ready=1 → req_ready[0] in the same cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_data=8'hA5.
- All 4 requesters valid continuously, MAX_BURST=4, rsp_ready=1 → grant pattern 0,0,0,0,1,1,1,1,2,…; responses in the same order with matching data.
- Requesters 1 and 3 valid, MAX_BURST=1 → alternating grants 1,3,1,3; the rr pointer wraps 3→0→1.
- rsp_ready=0 with requester 2 streaming 8'h10, 8'h11, … → exactly 2 accepts, then req_ready=0. rsp_data holds 8'h10 until rsp_ready=1, then 8'h11 follows, and issuing resumes with no loss.
- Assert rst_n=0 mid-burst with the queue full → rsp_valid and req_ready drop immediately. After release, the first grant goes to the lowest valid index from pointer 0.
- Build with DFF_SHARE_ARB_HOLD_INP_EN: after issuing 8'h3C followed by idle cycles, dff_inp stays 8'h3C. The response stream is identical to the undefined build.
